fft_input_framer: RTL and testbench

Ping-pong input buffer directly upstream of `fft_32point`. Accepts 32-bit real samples one per cycle over a valid/ready stream, assembles 32-sample frames, and presents each complete frame in parallel on the `in0_r`..`in31_r` inputs of the FFT, held stable until the consumer acknowledges it. Two banks allow one frame to fill while the previous one is held for the FFT, sustaining one sample per cycle.

---
 rtl/fft_input_framer.sv | 98 +++++++++
 tb/tb_fft_input_framer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_input_framer.sv
// Ping-pong frame buffer feeding fft_32point: collects N samples per bank and holds each full bank until released.
// Optional define FFT_FRAMER_LAST_CHECK_EN enables s_last framing checks and frame_err pulses.
module fft_input_framer #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned N      = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid,
   input  logic [DATA_W-1:0]     s_data,
   input  logic                  s_last,
   output logic                  s_ready,
   output logic [N*DATA_W-1:0]   frame_data,
   output logic                  frame_valid,
   input  logic                  frame_ready,
   output logic [7:0]            frame_cnt,
   output logic                  frame_err
);

   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   logic [DATA_W-1:0] bank [2][N];
   logic [1:0]        full;
   logic [1:0]        full_nxt;
   logic              wr_sel;
   logic              rd_sel;
   logic [IDX_W-1:0]  wr_idx;
   logic              accept_c;
   logic              release_c;
   logic              complete_c;
   logic              drop_c;
   logic              err_c;

   assign s_ready     = !rst && !full[wr_sel];
   assign frame_valid = full[rd_sel];
   assign accept_c    = s_valid && s_ready;
   assign release_c   = frame_valid && frame_ready;

`ifdef FFT_FRAMER_LAST_CHECK_EN
   // Early s_last drops the sample and restarts the frame; a missing s_last only flags.
   assign drop_c     = accept_c && s_last && (wr_idx != LAST_IDX);
   assign err_c      = drop_c || (accept_c && !s_last && (wr_idx == LAST_IDX));
`else
   logic unused_last;
   assign unused_last = s_last;
   assign drop_c      = 1'b0;
   assign err_c       = 1'b0;
`endif

   assign complete_c = accept_c && !drop_c && (wr_idx == LAST_IDX);

   // Fill and release always target different banks, so set and clear never collide.
   always_comb begin
      full_nxt = full;
      if (release_c) full_nxt[rd_sel] = 1'b0;
      if (complete_c) full_nxt[wr_sel] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < int'(N); k++) begin
               bank[b][k] <= '0;
            end
         end
         full      <= '0;
         wr_sel    <= 1'b0;
         rd_sel    <= 1'b0;
         wr_idx    <= '0;
         frame_cnt <= '0;
         frame_err <= 1'b0;
      end else begin
         if (accept_c && !drop_c) bank[wr_sel][wr_idx] <= s_data;
         if (drop_c) begin
            wr_idx <= '0;
         end else if (accept_c) begin
            wr_idx <= wr_idx + IDX_W'(1);
         end
         if (complete_c) wr_sel <= !wr_sel;
         if (release_c) begin
            rd_sel    <= !rd_sel;
            frame_cnt <= frame_cnt + 8'd1;
         end
         full      <= full_nxt;
         frame_err <= err_c;
      end
   end

   // Presented frame comes straight from the read bank's flops.
   always_comb begin
      frame_data = '0;
      for (int k = 0; k < int'(N); k++) begin
         frame_data[k*DATA_W +: DATA_W] = bank[rd_sel][k];
      end
   end

endmodule

// File: tb/tb_fft_input_framer.sv
// Bench for fft_input_framer: queue-of-frames model checked every cycle plus literal spot checks.
module tb_fft_input_framer;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned N      = 32;

   logic                clk;
   logic                rst;
   logic                s_valid;
   logic [DATA_W-1:0]   s_data;
   logic                s_last;
   logic                s_ready;
   logic [N*DATA_W-1:0] frame_data;
   logic                frame_valid;
   logic                frame_ready;
   logic [7:0]          frame_cnt;
   logic                frame_err;

   fft_input_framer #(.DATA_W(DATA_W), .N(N)) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
      .s_ready(s_ready), .frame_data(frame_data), .frame_valid(frame_valid),
      .frame_ready(frame_ready), .frame_cnt(frame_cnt), .frame_err(frame_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int bad   = 0;

   // Model: partial frame as a sample queue, complete frames as a FIFO of at most two.
   logic [DATA_W-1:0]   part [$];
   logic [N*DATA_W-1:0] frames [$];
   int                  m_cnt;
   bit                  m_err;
   bit                  m_zero;
   bit                  m_acc;
   logic [DATA_W-1:0]   next_val;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_data(input string name, input logic [N*DATA_W-1:0] exp);
      total++;
      if (frame_data !== exp) begin
         bad++;
         for (int k = 0; k < int'(N); k++) begin
            if (frame_data[k*DATA_W +: DATA_W] !== exp[k*DATA_W +: DATA_W]) begin
               $display("FAIL %s slice=%0d actual=%0h required=%0h t=%0t", name, k,
                        frame_data[k*DATA_W +: DATA_W], exp[k*DATA_W +: DATA_W], $time);
               break;
            end
         end
      end
   endtask

   task automatic model_update();
      logic [N*DATA_W-1:0] f;
      m_acc = 1'b0;
      if (rst) begin
         part.delete();
         frames.delete();
         m_cnt  = 0;
         m_err  = 1'b0;
         m_zero = 1'b1;
      end else begin
         m_acc  = s_valid && (frames.size() < 2);
         m_err  = 1'b0;
         m_zero = 1'b0;
         if (frames.size() > 0 && frame_ready) begin
            void'(frames.pop_front());
            m_cnt = (m_cnt + 1) % 256;
         end
         if (m_acc) begin
`ifdef FFT_FRAMER_LAST_CHECK_EN
            if (s_last && part.size() != N - 1) begin
               m_err = 1'b1;
               part.delete();
            end else begin
               if (!s_last && part.size() == N - 1) m_err = 1'b1;
               part.push_back(s_data);
            end
`else
            part.push_back(s_data);
`endif
            if (part.size() == N) begin
               for (int k = 0; k < int'(N); k++) f[k*DATA_W +: DATA_W] = part[k];
               frames.push_back(f);
               part.delete();
            end
         end
      end
   endtask

   task automatic compare();
      chk("s_ready", 32'(s_ready), 32'(!rst && frames.size() < 2));
      chk("frame_valid", 32'(frame_valid), 32'(frames.size() > 0));
      chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
      chk("frame_err", 32'(frame_err), 32'(m_err));
      if (frames.size() > 0) chk_data("frame_data", frames[0]);
      else if (m_zero) chk_data("frame_data_rst", '0);
   endtask

   // One cycle: drive at negedge, update model at the edge, compare just after it.
   task automatic step(input bit r, input bit v, input bit fr, input bit l);
      @(negedge clk);
      rst = r; s_valid = v; s_data = next_val; frame_ready = fr; s_last = l;
      @(posedge clk);
      model_update();
      #1;
      compare();
      if (m_acc) next_val = next_val + 32'd1;
   endtask

   int acc_n;
   int drops;
   int gap;
   int max_gap;
   bit seen;

   initial begin
      rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; frame_ready = 1'b0;
      next_val = '0; m_cnt = 0; m_err = 1'b0; m_zero = 1'b1;

      // Reset and a single frame with consumer always ready
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_frame_data0", frame_data[31:0], 32'd0);
      for (int i = 0; i < 32; i++) begin
         step(0, 1, 1, 0);
         if (i == 0) chk("post_rst_s_ready", 32'(s_ready), 32'd1);
         if (i == 30) chk("t1_not_yet_valid", 32'(frame_valid), 32'd0);
      end
      chk("t1_valid", 32'(frame_valid), 32'd1);
      chk("t1_slice5", frame_data[5*32 +: 32], 32'h5);
      chk("t1_slice31", frame_data[31*32 +: 32], 32'h1F);
      chk("t1_cnt0", 32'(frame_cnt), 32'd0);
      step(0, 0, 1, 0);
      chk("t1_cnt1", 32'(frame_cnt), 32'd1);
      chk("t1_released", 32'(frame_valid), 32'd0);

      // Fill both banks with no consumer, then drain in order
      next_val = '0;
      for (int i = 0; i < 96; i++) begin
         step(0, 1, 0, 0);
         if (i == 63) chk("t2_stall", 32'(s_ready), 32'd0);
      end
      chk("t2_first_slice0", frame_data[31:0], 32'h00);
      chk("t2_first_slice31", frame_data[31*32 +: 32], 32'h1F);
      step(0, 1, 1, 0);
      chk("t2_second_slice0", frame_data[31:0], 32'h20);
      chk("t2_second_slice31", frame_data[31*32 +: 32], 32'h3F);
      acc_n = 0;
      for (int i = 0; i < 60 && acc_n < 32; i++) begin
         step(0, 1, 1, 0);
         if (m_acc) acc_n++;
      end
      chk("t2_third_accepts", 32'(acc_n), 32'd32);
      chk("t2_third_slice0", frame_data[31:0], 32'h40);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
      chk("t2_cnt", 32'(frame_cnt), 32'd4);

      // Continuous stream, release one cycle after each frame appears
      drops = 0; gap = 0; max_gap = 0; seen = 1'b0;
      for (int i = 0; i < 130; i++) begin
         step(0, 1, frames.size() > 0, 0);
         if (s_ready !== 1'b1) drops++;
         if (frame_valid) begin
            if (seen && gap > max_gap) max_gap = gap;
            seen = 1'b1;
            gap = 0;
         end else if (seen) begin
            gap++;
         end
      end
      chk("t3_no_stall", 32'(drops), 32'd0);
      chk("t3_gap_le_31", 32'(max_gap <= 31 && seen), 32'd1);

      // Random input gaps and random consumer
      for (int i = 0; i < 300; i++) step(0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, 0);
      for (int i = 0; i < 100 && part.size() != 0; i++) step(0, 1, 1, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
      chk("t4_drained", 32'(frame_valid), 32'd0);

      // Reset with one full frame and a partial frame
      next_val = 32'h100;
      for (int i = 0; i < 49; i++) step(0, 1, 0, 0);
      chk("t5_pre_valid", 32'(frame_valid), 32'd1);
      step(1, 0, 0, 0);
      chk("t5_valid", 32'(frame_valid), 32'd0);
      chk("t5_cnt", 32'(frame_cnt), 32'd0);
      chk("t5_data", frame_data[17*32 +: 32], 32'd0);
      next_val = '0;
      for (int i = 0; i < 32; i++) step(0, 1, 0, 0);
      chk("t5_slice0", frame_data[31:0], 32'h0);
      chk("t5_slice16", frame_data[16*32 +: 32], 32'h10);
      chk("t5_slice31", frame_data[31*32 +: 32], 32'h1F);
      step(0, 0, 1, 0);
      chk("t5_cnt1", 32'(frame_cnt), 32'd1);

`ifdef FFT_FRAMER_LAST_CHECK_EN
      // Early s_last aborts the frame; late s_last flags but completes
      next_val = 32'h200;
      for (int i = 0; i < 11; i++) step(0, 1, 0, i == 10);
      chk("t6_err_pulse", 32'(frame_err), 32'd1);
      step(0, 0, 0, 0);
      chk("t6_err_clear", 32'(frame_err), 32'd0);
      chk("t6_no_frame", 32'(frame_valid), 32'd0);
      next_val = 32'h300;
      for (int i = 0; i < 32; i++) step(0, 1, 0, i == 31);
      chk("t6_frame", 32'(frame_valid), 32'd1);
      chk("t6_slice0", frame_data[31:0], 32'h300);
      chk("t6_no_err", 32'(frame_err), 32'd0);
      step(0, 0, 1, 0);
      for (int i = 0; i < 32; i++) step(0, 1, 0, 0);
      chk("t6_missing_last_err", 32'(frame_err), 32'd1);
      chk("t6_missing_last_frame", 32'(frame_valid), 32'd1);
      step(0, 0, 1, 0);
`else
      // s_last is ignored without the check option
      next_val = 32'h200;
      for (int i = 0; i < 32; i++) step(0, 1, 0, i == 10);
      chk("t6_ignored_err", 32'(frame_err), 32'd0);
      chk("t6_ignored_frame", 32'(frame_valid), 32'd1);
      chk("t6_ignored_slice11", frame_data[11*32 +: 32], 32'h20B);
      step(0, 0, 1, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
